// File: rtl/systolic_stream_skewer.sv
// Staircase skewer that feeds A rows and B columns into a systolic array. It supports OS, WS_LOAD and WS_COMP tile modes.
// Optional SYSTOLIC_SKEW_BEAT_CNT_EN adds a per-tile accepted-beat counter output.

module skew_lane #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  bypass,
  input  logic                  dv,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  qv
);
  logic [DEPTH-1:0][DATA_WIDTH-1:0] dat;
  logic [DEPTH-1:0]                 vld_pipe;

  // In bypass mode the tail stages only ever hold zeros.
  // A later tile in skewed mode therefore never sees stale bypassed data.
  always_ff @(posedge clk) begin
    if (rst) begin
      dat      <= '0;
      vld_pipe <= '0;
    end else if (en) begin
      dat[0]      <= dv ? d : '0;
      vld_pipe[0] <= dv;
      for (int k = 1; k < DEPTH; k++) begin
        dat[k]      <= bypass ? '0 : dat[k-1];
        vld_pipe[k] <= ~bypass & vld_pipe[k-1];
      end
    end
  end

  assign q  = bypass ? dat[0]      : dat[DEPTH-1];
  assign qv = bypass ? vld_pipe[0] : vld_pipe[DEPTH-1];
endmodule

module systolic_stream_skewer #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 4,
  parameter int COLS       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 mode,
  input  logic                       stall,
  input  logic                       in_valid,
  input  logic                       in_last,
  output logic                       in_ready,
  input  logic [DATA_WIDTH*ROWS-1:0] a_in,
  input  logic [DATA_WIDTH*COLS-1:0] b_in,
  output logic [DATA_WIDTH*ROWS-1:0] a_out,
  output logic [DATA_WIDTH*COLS-1:0] b_out,
  output logic [ROWS-1:0]            a_lane_valid,
  output logic [COLS-1:0]            b_lane_valid,
  output logic                       busy,
  output logic                       done
`ifdef SYSTOLIC_SKEW_BEAT_CNT_EN
  , output logic [15:0]              beat_count
`endif
);
  localparam logic [1:0] M_OS  = 2'b00;
  localparam logic [1:0] M_WSL = 2'b01;
  localparam logic [1:0] M_WSC = 2'b10;
  localparam int MAXRC = (ROWS > COLS) ? ROWS : COLS;
  localparam int CW    = (MAXRC > 1) ? $clog2(MAXRC + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t          state, state_d;
  logic [1:0]      mode_q, mode_d, eff_mode;
  logic [CW-1:0]   cnt, cnt_d, drain_d;
  logic            accept, adv, a_dv, b_dv, b_bypass;

  assign in_ready = ~stall & (state == S_IDLE || state == S_STREAM);
  assign accept   = in_valid & in_ready;
  assign adv      = ~stall;
  assign busy     = (state == S_STREAM) || (state == S_DRAIN);
  assign done     = (state == S_DONE);
  // Mode is taken live only for the opening beat of a tile.
  assign eff_mode = (state == S_IDLE) ? mode : mode_q;
  assign a_dv     = accept & (eff_mode != M_WSL);
  assign b_dv     = accept & (eff_mode != M_WSC);
  assign b_bypass = (mode_q == M_WSL);

  always_comb begin
    case (eff_mode)
      M_WSL:   drain_d = '0;
      M_WSC:   drain_d = CW'(ROWS - 1);
      default: drain_d = CW'(MAXRC - 1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      mode_q <= M_OS;
    end else if (adv) begin
      state  <= state_d;
      cnt    <= cnt_d;
      mode_q <= mode_d;
    end
  end

  // Zero drain depth skips DRAIN so done lands on the cycle right after the last beat.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    mode_d  = mode_q;
    case (state)
      S_IDLE, S_STREAM: begin
        if (accept) begin
          mode_d  = eff_mode;
          state_d = S_STREAM;
          if (in_last) begin
            cnt_d   = drain_d;
            state_d = (drain_d == '0) ? S_DONE : S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        cnt_d = cnt - CW'(1);
        if (cnt == CW'(1)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_a
    skew_lane #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(i + 1)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .en     (adv),
      .bypass (1'b0),
      .dv     (a_dv),
      .d      (a_in[i*DATA_WIDTH +: DATA_WIDTH]),
      .q      (a_out[i*DATA_WIDTH +: DATA_WIDTH]),
      .qv     (a_lane_valid[i])
    );
  end

  for (genvar j = 0; j < COLS; j++) begin : g_b
    skew_lane #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(j + 1)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .en     (adv),
      .bypass (b_bypass),
      .dv     (b_dv),
      .d      (b_in[j*DATA_WIDTH +: DATA_WIDTH]),
      .q      (b_out[j*DATA_WIDTH +: DATA_WIDTH]),
      .qv     (b_lane_valid[j])
    );
  end

`ifdef SYSTOLIC_SKEW_BEAT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_count <= '0;
    end else if (adv && accept) begin
      if (state == S_IDLE)             beat_count <= 16'd1;
      else if (beat_count != 16'hFFFF) beat_count <= beat_count + 16'd1;
    end
  end
`endif
endmodule

// File: doc/systolic_stream_skewer.md
Name: systolic_stream_skewer

Overview:
- Parametrised successor to the systolic input controller: feeds A (row lanes) and B (column lanes) into the PE array with per-lane staircase skew, WS weight-load bypass, and a new WS-compute mode.
- Adds valid/ready input handshake, stall, end-of-tile drain and per-lane valid tags.
- Sits between the operand buffers and the systolic array; one instance per array.

Parameters:
- DATA_WIDTH, 8, bits per lane element (signed).
- ROWS, 4, number of A lanes (array rows), ≥1.
- COLS, 4, number of B lanes (array columns), ≥1.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  2  00 OS, 01 WS_LOAD, 10 WS_COMP, 11 reserved (treated as OS); sampled only on the first accepted beat of a tile.
- stall  in  1  freezes all state and outputs while high.
- in_valid  in  1  A/B beat present.
- in_last  in  1  marks final beat of tile; qualified by in_valid.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- a_in  in  DATA_WIDTH*ROWS  lane i at [i*DATA_WIDTH +: DATA_WIDTH].
- b_in  in  DATA_WIDTH*COLS  lane j likewise.
- a_out  out  DATA_WIDTH*ROWS  skewed A to array.
- b_out  out  DATA_WIDTH*COLS  skewed/aligned B to array.
- a_lane_valid  out  ROWS  bit i: a_out lane i carries real data.
- b_lane_valid  out  COLS  bit j: b_out lane j carries real data.
- busy  out  1  high in STREAM or DRAIN.
- done  out  1  one-cycle pulse, tile fully presented.

Behaviour:
- Reset (rst=1 at clk edge): all skew registers, a_out, b_out, lane valids, busy, done = 0; FSM = IDLE; latched mode = OS. Reset wins over stall and mid-tile activity: the tile is discarded with no done pulse.
- FSM states: IDLE, STREAM, DRAIN, DONE.
  - IDLE to STREAM on the first accepted beat; mode is latched then. If that beat also has in_last, go directly to DRAIN.
  - STREAM to DRAIN on an accepted beat with in_last.
  - DRAIN to DONE when the drain counter reaches 0.
  - DONE to IDLE after 1 cycle.
- in_ready = ~stall & (state==IDLE | state==STREAM). It is combinational from state and stall only; it never depends on in_valid.
- Lane latency from acceptance edge T:
  - OS: A lane i appears at T+1+i; B lane j at T+1+j.
  - WS_LOAD: B lane j at T+1 (all aligned, bypass); A lanes output 0 with valid 0.
  - WS_COMP: A lane i at T+1+i; B lanes output 0 with valid 0 (weights are resident in the PEs).
- Bubbles: a cycle with no accepted beat (in_valid=0 while not stalled) injects a zero element with valid=0 into lane stage 0. It travels through the skew exactly like data. Lanes with valid=0 always output 0.
- Drain depth D:
  - OS: max(ROWS,COLS)-1.
  - WS_LOAD: 0.
  - WS_COMP: ROWS-1.
- On the last-beat edge, load the counter with D. DRAIN decrements each unstalled cycle; entering DONE requires counter==0.
- done is high in the cycle the last valid element is on its final lane (T+1+D) and coincides with the DONE state.
- stall=1: no register updates, outputs hold their values, done held if already high, in_ready=0. A beat offered during stall is not accepted.
- mode changes while busy are ignored until the next IDLE acceptance.
- in_last while in DRAIN/DONE is ignored, since in_ready=0.
- Skew implementation: lane i of A has i+1 register stages and lane j of B has j+1. WS_LOAD bypasses all B stages except the first.

Optional Feature:
- Macro SYSTOLIC_SKEW_BEAT_CNT_EN.
- Defined: adds output beat_count [15:0].
  - Cleared by rst and on each IDLE to STREAM/DRAIN transition.
  - Increments on every accepted beat, saturating at 16'hFFFF.
  - Holds its value after done until the next tile starts.
- Not defined: port absent, no counter logic; all other behaviour identical.

Test Plan:
- Reset mid-tile: rst=1 during STREAM of an OS tile. Next edge: all outputs 0, state IDLE, done never pulses, in_ready=1 next cycle.
- WS_LOAD, ROWS=COLS=4: b_in={40,30,20,10}, in_last=1 accepted at T. At T+1: b_out={40,30,20,10}, b_lane_valid=4'b1111, a_lane_valid=0, done=1. At T+2: idle, all zero.
- OS streaming, 4x4: 6 beats of value k (1..6) on all lanes, last at beat 6.
  - Lane i shows k at cycle T_k+1+i.
  - a_out = {01,02,03,04} (lane3..lane0) at beat-4 acceptance edge +1.
  - done at T_6+4; lane valids fall in staircase order.
- Bubble: OS, beats 1, gap, 2 (in_valid=0 one cycle). Lane 3 shows 1, 0 (valid 0), 2 on consecutive cycles.
- Stall: assert stall 3 cycles mid-OS-stream. Outputs frozen, in_ready=0, a beat offered is not consumed. After release, the sequence resumes unchanged and done is delayed by exactly 3 cycles.
- WS_COMP, ROWS=4, COLS=2, with macro defined: 5 beats. b_out=0 throughout, A staircased, done at T_5+4, beat_count=5.
